// File: rtl/simple_caculator.sv
// UART byte calculator: receives A, operator, B (8N1); replies with one 8-bit result frame.
// Latency: TX start bit begins 2 clocks after the B stop-bit mid-sample; no backpressure, E=0 ignores received bytes.
module simple_caculator #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic CLK,
    input  logic RST,
    input  logic E,
    input  logic RX,
    output logic TX
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CW       = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h78;
    localparam logic [7:0] OP_DIV = 8'h2F;

    typedef enum logic [2:0] {WAIT_A, WAIT_OP, WAIT_B, CALC, SEND} state_t;

    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          byte_vld;
    logic [7:0]    byte_dat;
    logic          rx_fall, rx_tick;

    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_tick, tx_done, tx_start;

    state_t        state, next_state;
    logic [7:0]    a_reg, b_reg, op_reg, res_reg, calc_res;
    logic          a_pend, op_ok;

    assign rx_fall = rx_prev & ~rx_s2;
    // Start bit is sampled half a bit in; every later bit one full bit after the previous sample.
    assign rx_tick = rx_busy && (rx_bit == 4'd0 ? (rx_cnt == HALF_LAST) : (rx_cnt == DIV_LAST));

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            byte_vld <= 1'b0;
            byte_dat <= '0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            byte_vld <= 1'b0;
            if (!rx_busy) begin
                if (rx_fall) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_tick) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else if (rx_bit <= 4'd8) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end else begin
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        byte_vld <= 1'b1;
                        byte_dat <= rx_shift;
                    end
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    assign tx_start = (state == CALC) && E;
    assign tx_tick  = tx_busy && (tx_cnt == DIV_LAST);
    assign tx_done  = tx_tick && (tx_bit == 4'd9);

    // Data bits are read straight from res_reg, which is loaded on the same edge the frame starts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            TX      <= 1'b1;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            TX      <= 1'b0;
        end else if (tx_busy) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    TX      <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                    TX     <= (tx_bit == 4'd8) ? 1'b1 : res_reg[tx_bit[2:0]];
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end else begin
            TX <= 1'b1;
        end
    end

    assign op_ok = (byte_dat == OP_ADD) || (byte_dat == OP_SUB) ||
                   (byte_dat == OP_MUL) || (byte_dat == OP_DIV);

    always_comb begin
        calc_res = 8'h00;
        unique case (op_reg)
            OP_ADD:  calc_res = a_reg + b_reg;
            OP_SUB:  calc_res = a_reg - b_reg;
            OP_MUL:  calc_res = a_reg * b_reg;
            OP_DIV:  calc_res = (b_reg == 8'h00) ? 8'hFF : a_reg / b_reg;
            default: calc_res = 8'h00;
        endcase
    end

    always_comb begin
        next_state = state;
        if (E) begin
            unique case (state)
                WAIT_A:  if (byte_vld) next_state = WAIT_OP;
                WAIT_OP: if (byte_vld) next_state = op_ok ? WAIT_B : WAIT_A;
                WAIT_B:  if (byte_vld) next_state = CALC;
                CALC:    next_state = SEND;
                SEND:    if (tx_done || !tx_busy)
                             next_state = (a_pend || byte_vld) ? WAIT_OP : WAIT_A;
                default: next_state = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= WAIT_A;
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            res_reg <= '0;
            a_pend  <= 1'b0;
        end else begin
            state <= next_state;
            if (E) begin
                unique case (state)
                    WAIT_A:  if (byte_vld) a_reg  <= byte_dat;
                    WAIT_OP: if (byte_vld) op_reg <= byte_dat;
                    WAIT_B:  if (byte_vld) b_reg  <= byte_dat;
                    CALC:    res_reg <= calc_res;
                    SEND: begin
                        if (byte_vld) begin
                            a_reg  <= byte_dat;
                            a_pend <= 1'b1;
                        end
                        if (next_state != SEND) a_pend <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_simple_caculator.sv
// Directed bench for simple_caculator: drives UART frames on RX and decodes TX frames into a queue.
module tb_simple_caculator;
    localparam int DIV  = 16;
    localparam int HALF = 8;

    logic CLK = 1'b0;
    logic RST, E, RX, TX;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int b_start  = 0;

    logic [7:0] got_q[$];
    logic       stop_q[$];
    int         at_q[$];

    simple_caculator #(.CLK_FREQ(160), .BAUD(10)) dut (
        .CLK(CLK), .RST(RST), .E(E), .RX(RX), .TX(TX)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin : tx_monitor
        logic [7:0] d;
        int t;
        forever begin
            @(negedge TX);
            #1;
            t = cyc;
            repeat (HALF) @(posedge CLK);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge CLK);
                #1 d[i] = TX;
            end
            repeat (DIV) @(posedge CLK);
            #1;
            got_q.push_back(d);
            stop_q.push_back(TX);
            at_q.push_back(t);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        b_start = cyc;
        RX = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(DIV);
        end
        RX = stop;
        tick(DIV);
        if (!stop) begin
            RX = 1'b1;
            tick(DIV);
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        stop_q.delete();
        at_q.delete();
    endtask

    task automatic calc(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
        send_byte(a);
        send_byte(op);
        send_byte(b);
        tick(12 * DIV);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] exp);
        check({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check({tag, "_value"}, got_q[0], exp);
            check({tag, "_stop"}, stop_q[0], 1);
        end
        clear_q();
    endtask

    logic [7:0] va [6] = '{8'd30, 8'd5,  8'd15, 8'd20, 8'd50, 8'd15};
    logic [7:0] vo [6] = '{8'h2D, 8'h2D, 8'h78, 8'h78, 8'h2F, 8'h2F};
    logic [7:0] vb [6] = '{8'd20, 8'd10, 8'd10, 8'd20, 8'd5,  8'd0};
    logic [7:0] ve [6] = '{8'd10, 8'hFB, 8'd150, 8'h90, 8'd10, 8'hFF};

    initial begin
        bit found;
        RX  = 1'b1;
        E   = 1'b1;
        RST = 1'b1;
        tick(3);
        check("reset_tx_idle", TX, 1);
        RST = 1'b0;
        tick(DIV);
        check("idle_tx_high", TX, 1);

        calc(8'h05, 8'h2B, 8'h0A);
        if (at_q.size() >= 1)
            check("add_latency_window", ((at_q[0] - b_start) >= 150) && ((at_q[0] - b_start) <= 165), 1);
        expect_one("add_5_10", 8'h0F);

        for (int i = 0; i < 6; i++) begin
            calc(va[i], vo[i], vb[i]);
            expect_one($sformatf("arith_%0d", i), ve[i]);
        end

        send_byte(8'd5);
        send_byte(8'h3F);
        tick(12 * DIV);
        check("bad_op_no_tx", got_q.size(), 0);
        clear_q();
        calc(8'd7, 8'h2B, 8'd1);
        expect_one("after_bad_op", 8'd8);

        send_byte(8'd3);
        send_byte(8'h2B, 1'b0);
        send_byte(8'h2D);
        send_byte(8'd1);
        tick(12 * DIV);
        expect_one("framing_err_discard", 8'd2);

        send_byte(8'd4);
        send_byte(8'h2B);
        send_byte(8'd4);
        send_byte(8'd9);
        send_byte(8'h2D);
        send_byte(8'd2);
        tick(12 * DIV);
        check("send_latch_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("send_latch_first", got_q[0], 8'd8);
            check("send_latch_second", got_q[1], 8'd7);
        end
        clear_q();

        E = 1'b0;
        calc(8'd5, 8'h2B, 8'd10);
        check("enable_low_no_tx", got_q.size(), 0);
        clear_q();
        E = 1'b1;

        send_byte(8'd30);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(DIV);
        calc(8'd30, 8'h2D, 8'd20);
        expect_one("reset_after_a", 8'd10);

        RX = 1'b0;
        tick(3 * DIV);
        RST = 1'b1;
        tick(1);
        RX = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(2 * DIV);
        calc(8'd6, 8'h78, 8'd7);
        expect_one("reset_mid_rx", 8'd42);

        send_byte(8'd1);
        send_byte(8'h2B);
        send_byte(8'd1);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (TX == 1'b0) found = 1'b1;
            else tick(1);
        end
        check("mid_tx_frame_started", found, 1);
        tick(40);
        RST = 1'b1;
        tick(1);
        check("mid_tx_reset_tx_high", TX, 1);
        RST = 1'b0;
        tick(DIV);
        check("mid_tx_stays_high", TX, 1);
        tick(12 * DIV);
        clear_q();
        calc(8'd50, 8'h2F, 8'd5);
        expect_one("after_tx_abort", 8'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/simple_caculator.md
SIMPLE_CACULATOR -- requirements
Module: simple_caculator

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning UART bit rate; BAUD_DIV = CLK_FREQ/BAUD clocks per bit (integer division).
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; reset is synchronous and active-high.
REQ-005 SHALL have port E  input  1  enable; 1 = accept and process received bytes.
REQ-006 SHALL have port RX  input  1  asynchronous UART serial input, idle high.
REQ-007 SHALL have port TX  output  1  UART serial output, idle high.

Function
REQ-008 SHALL use UART framing 8N1 on both RX and TX: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_DIV clocks.
REQ-009 SHALL pass RX through a 2-flop synchronizer before any use.
REQ-010 Receiver SHALL detect the start bit on a synchronized falling edge and sample the start bit and each data bit at mid-bit (BAUD_DIV/2 after the bit edge).
REQ-011 Receiver SHALL discard a frame if the start bit samples 1 at mid-bit (glitch) or the stop bit samples 0 (framing error).
REQ-012 Receiver SHALL issue a one-cycle byte-valid pulse with the byte at the stop-bit mid-sample.
REQ-013 Receiver SHALL be ready for the next start bit immediately after the stop-bit sample.
REQ-014 Control FSM states SHALL be WAIT_A, WAIT_OP, WAIT_B, CALC, SEND.
REQ-015 In WAIT_A, a valid byte SHALL be stored as operand A (unsigned 8-bit); next state WAIT_OP.
REQ-016 In WAIT_OP, a valid byte SHALL be stored as the operator.
REQ-017 The accepted operator codes SHALL be '+' 0x2B, '-' 0x2D, 'x' 0x78, '/' 0x2F; an accepted code moves to WAIT_B.
REQ-018 Any other operator byte SHALL discard the transaction and return to WAIT_A; nothing is transmitted.
REQ-019 In WAIT_B, a valid byte SHALL be stored as operand B; next state CALC.
REQ-020 CALC SHALL last one clock and register an 8-bit result.
REQ-021 Addition SHALL be (A+B) mod 256; subtraction SHALL be (A-B) mod 256; multiplication SHALL keep the low 8 bits of A*B.
REQ-022 Division SHALL be unsigned floor(A/B); B=0 SHALL give result 0xFF.
REQ-023 On leaving CALC, the transmitter SHALL be started with the result; start bit begins on the cycle after CALC.
REQ-024 SEND SHALL hold until the stop bit completes (10*BAUD_DIV clocks), then go to WAIT_A.
REQ-025 The receiver SHALL keep running during SEND.
REQ-026 A byte received during SEND SHALL be latched as operand A; the FSM then goes to WAIT_OP once SEND ends.
REQ-027 When E=0, byte-valid pulses SHALL be ignored and the FSM SHALL hold its state; a transmission already in progress SHALL complete.
REQ-028 Transmitter SHALL drive TX=1 whenever not sending a frame.
REQ-029 At most one result byte SHALL be transmitted per operand-operator-operand triple.

Reset
REQ-030 While RST=1 at a clock edge: FSM to WAIT_A; A, B, operator and result cleared to 0; RX and TX engines to idle with bit counters cleared; TX=1 the following cycle.
REQ-031 RST asserted mid-reception SHALL abort the partial frame; RST asserted mid-transmission SHALL abort the frame and drive TX high.

Verification
REQ-032 E=1, send 0x05, 0x2B, 0x0A -> one TX frame 0x0F (15) starting 1 clock after CALC.
REQ-033 Send 30,'-',20 -> 10; send 5,'-',10 -> 0xFB (251 wrap).
REQ-034 Send 15,'x',10 -> 150; send 20,'x',20 -> 0x90 (400 mod 256).
REQ-035 Send 50,'/',5 -> 10; send 15,'/',0 -> 0xFF.
REQ-036 Send 5,'?',... -> no TX; then 7,'+',1 -> 8; frame with stop bit 0 -> discarded, no state change.
REQ-037 E=0 during 5,'+',10 -> no TX; RST pulse after A received -> next 30,'-',20 yields 10.
